// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Supplies the default clock frequency, baud rate and oversampling factor,
// plus the divisor calculation used by the baud generator, the RX/TX
// samplers and their benches.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQUENCY = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE     = 9600;
  localparam int unsigned DEF_SAMPLING      = 16;

  // System clocks per oversample tick, truncated toward zero.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned sampling);
    return clk_hz / (baud * sampling);
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Generic modulo-N event counter.
// Counts enabled cycles from 0 to N-1 and then wraps to 0. The wrap
// condition is a greater-or-equal compare, so if N is lowered below the
// current count, the counter wraps on the next enabled cycle instead of
// running on to the top of its range.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   i_en   : count enable
//   i_n    : modulus; sampled live every cycle (0 behaves like 1)
//   o_wrap : combinational, high in the cycle whose edge wraps the count
module uart_tick_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_n,
  output logic         o_wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  // i_n == 0 would underflow i_n-1, so it is handled as "always last".
  assign w_last = (i_n == '0) || (r_cnt >= (i_n - ONE));
  assign o_wrap = i_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : (r_cnt + ONE);
    end
  end

endmodule

// File: rtl/uart_baud_generator.sv
// UART oversampling tick generator.
// Divides the system clock to produce bclk, a one-cycle pulse at
// BAUD_RATE*SAMPLING Hz, and bit_tick, a one-cycle pulse coincident with
// every SAMPLING-th bclk pulse (once per bit period).
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bclk     : registered oversample tick
//   bit_tick : registered bit tick, coincident with every SAMPLING-th bclk
//
// The divisor is held on the plain internal signal n so it can be forced
// from a bench to retarget the rate without re-elaboration.
module uart_baud_generator
  import uart_pkg::*;
#(
  parameter int unsigned SAMPLING      = DEF_SAMPLING,
  parameter int unsigned CLK_FREQUENCY = DEF_CLK_FREQUENCY,
  parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic bit_tick
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQUENCY, BAUD_RATE, SAMPLING);
  localparam int unsigned SW      = $clog2(SAMPLING) + 1;

  if (SAMPLING < 1) begin : g_bad_sampling
    $error("uart_baud_generator: SAMPLING must be at least 1");
  end
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_baud_generator: DIVISOR must be at least 2");
  end

  logic [31:0] n;
  logic [31:0] w_n_eff;
  logic        w_bclk_set;
  logic        w_bit_set;
  logic        r_bclk;
  logic        r_bit_tick;

  assign n = DIVISOR;

  // A forced divisor below 2 would hold bclk permanently high; clamp it.
  assign w_n_eff = (n < 32'd2) ? 32'd2 : n;

  uart_tick_counter #(
    .W (32)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (1'b1),
    .i_n    (w_n_eff),
    .o_wrap (w_bclk_set)
  );

  // Advances only on the edge that raises bclk, so its wrap lands on the
  // same edge as the corresponding bclk pulse.
  uart_tick_counter #(
    .W (SW)
  ) u_sample_div (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_bclk_set),
    .i_n    (SW'(SAMPLING)),
    .o_wrap (w_bit_set)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk     <= 1'b0;
      r_bit_tick <= 1'b0;
    end else begin
      r_bclk     <= w_bclk_set;
      r_bit_tick <= w_bit_set;
    end
  end

  assign bclk     = r_bclk;
  assign bit_tick = r_bit_tick;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Self-checking bench for uart_baud_generator (100 MHz, 9600 baud, x16).
// Reference model: bclk fires once a full divisor's worth of rising edges
// has elapsed since the last pulse (or since reset release); bit_tick
// fires on every 16th such pulse. Rates are retargeted by forcing dut.n.
module tb_uart_baud_generator;

  localparam int unsigned S      = 16;
  localparam int unsigned TCLK   = 10;
  localparam int unsigned N_9600 = 100_000_000 / (9600 * 16);

  logic clk = 1'b0;
  logic reset;
  logic bclk;
  logic bit_tick;

  logic [31:0] fn;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state.
  int unsigned neff;
  int unsigned since;
  int unsigned pulses;
  logic        exp_b;
  logic        exp_t;
  longint      t_last_b;
  longint      t_last_t;
  bit          b_valid;
  bit          t_valid;

  uart_baud_generator #(
    .SAMPLING      (16),
    .CLK_FREQUENCY (100_000_000),
    .BAUD_RATE     (9600)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_t(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: advance the model on the rising edge, compare 1 ns later.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      since++;
      if (since >= neff) begin
        since  = 0;
        pulses++;
        exp_b  = 1'b1;
        exp_t  = ((pulses % S) == 0);
      end else begin
        exp_b = 1'b0;
        exp_t = 1'b0;
      end
    end else begin
      since  = 0;
      pulses = 0;
      exp_b  = 1'b0;
      exp_t  = 1'b0;
    end
    #1;
    chk("bclk", bclk, exp_b);
    chk("bit_tick", bit_tick, exp_t);
    if (exp_b && bclk) begin
      if (b_valid) chk_t("bclk_interval_ns", $time - t_last_b, longint'(neff) * TCLK);
      t_last_b = $time;
      b_valid  = 1'b1;
    end
    if (exp_t && bit_tick) begin
      if (t_valid) chk_t("bit_interval_ns", $time - t_last_t, longint'(neff) * S * TCLK);
      t_last_t = $time;
      t_valid  = 1'b1;
    end
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, hold, release.
  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    reset   = 1'b0;
    b_valid = 1'b0;
    t_valid = 1'b0;
    #1;
    chk("rst_async_bclk", bclk, 1'b0);
    chk("rst_async_bit_tick", bit_tick, 1'b0);
    run(cycles);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_n(input int unsigned v);
    @(negedge clk);
    fn = v;
    force dut.n = fn;
    neff    = (v < 2) ? 2 : v;
    b_valid = 1'b0;
    t_valid = 1'b0;
  endtask

  // Run until the chosen output is expected high, then pull reset while
  // that output is still high and confirm it drops without a clock edge.
  task automatic reset_on_pulse(input bit want_tick, input int unsigned budget);
    bit found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      step();
      if (want_tick ? exp_t : exp_b) found = 1'b1;
    end
    chk("pulse_seen_before_reset", found, 1'b1);
    #2;
    reset   = 1'b0;
    b_valid = 1'b0;
    t_valid = 1'b0;
    #1;
    chk("rst_on_pulse_bclk", bclk, 1'b0);
    chk("rst_on_pulse_bit_tick", bit_tick, 1'b0);
    run(2);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int unsigned rates[4] = '{325, 162, 108, 54};
    reset    = 1'b0;
    fn       = '0;
    neff     = N_9600;
    since    = 0;
    pulses   = 0;
    exp_b    = 1'b0;
    exp_t    = 1'b0;
    t_last_b = 0;
    t_last_t = 0;
    b_valid  = 1'b0;
    t_valid  = 1'b0;

    // Outputs are cleared by reset before any clock edge.
    #1;
    chk("reset_bclk", bclk, 1'b0);
    chk("reset_bit_tick", bit_tick, 1'b0);

    // 9600 baud: first pulse after 651 edges, then 6510 ns spacing;
    // bit_tick every 16 pulses (104160 ns).
    do_reset(3);
    run(2 * N_9600 + 5);
    run(2 * S * N_9600);

    // Reset about 300 clocks into a period; restart exactly from zero.
    reset_on_pulse(1'b0, N_9600 + 2);
    run(300);
    do_reset(2);
    run(N_9600 + 10);

    // Reset while bit_tick (and bclk) are high.
    reset_on_pulse(1'b1, S * N_9600 + 2);
    run(N_9600 + 5);

    // Forced faster rates.
    foreach (rates[k]) begin
      set_n(rates[k]);
      do_reset(2);
      run(3 * rates[k] + 5);
    end

    // Lower n while the count is far above the new limit.
    set_n(N_9600);
    do_reset(2);
    run(400);
    set_n(54);
    step();
    chk("wrap_after_force", bclk, 1'b1);
    run(200);

    // Degenerate divisors never hold bclk high.
    set_n(1);
    do_reset(2);
    run(40);
    set_n(0);
    run(40);

    // Randomized divisors, reset lengths and mid-run changes.
    for (int t = 0; t < 8; t++) begin
      int unsigned v;
      v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 400);
      set_n(v);
      do_reset($urandom_range(1, 5));
      run($urandom_range(2, 4) * neff + $urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) begin
        set_n($urandom_range(2, 300));
        run(2 * neff + $urandom_range(0, 20));
      end
    end

    release dut.n;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
